// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake and NZCV flags.
// Optional feature macro: PIPELINED_ADDSUB_FLAGS_EN (flags built when defined, tied to 0 otherwise).
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned S  = WIDTH / STAGES;
  localparam int unsigned SW = S + 1;

  // Global stall: the whole pipe moves only when the output slot can drain.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    logic                 vin;
    logic                 c_in;
    logic [S-1:0]         a_s;
    logic [S-1:0]         b_s;
    logic [S-1:0]         s_s;
    logic [(k+1)*S-1:0]   res_in;
    logic [(k+1)*S-1:0]   res;
    logic                 vld;
`ifdef PIPELINED_ADDSUB_FLAGS_EN
    logic                 z_in;
`endif

    // Slice operands: stage 0 takes the inputs (B inverted on subtract), later stages the skewed remainder.
    if (k == 0) begin : g_in
      assign vin    = in_valid;
      assign a_s    = a[S-1:0];
      assign b_s    = sub ? ~b[S-1:0] : b[S-1:0];
      assign c_in   = sub | cin;
      assign res_in = s_s;
`ifdef PIPELINED_ADDSUB_FLAGS_EN
      assign z_in   = 1'b1;
`endif
    end else begin : g_in
      assign vin    = stg[k-1].vld;
      assign a_s    = stg[k-1].g_rem.a_rem[S-1:0];
      assign b_s    = stg[k-1].g_rem.b_rem[S-1:0];
      assign c_in   = stg[k-1].g_rem.c_q;
      assign res_in = {s_s, stg[k-1].res};
`ifdef PIPELINED_ADDSUB_FLAGS_EN
      assign z_in   = stg[k-1].g_rem.z_q;
`endif
    end

    if (k < STAGES - 1) begin : g_rem
      localparam int unsigned RW = WIDTH - (k + 1) * S;
      logic          c_out;
      logic          c_q;
      logic [RW-1:0] a_nx;
      logic [RW-1:0] b_nx;
      logic [RW-1:0] a_rem;
      logic [RW-1:0] b_rem;
`ifdef PIPELINED_ADDSUB_FLAGS_EN
      logic          z_q;
`endif

      assign {c_out, s_s} = {1'b0, a_s} + {1'b0, b_s} + SW'(c_in);

      // Unprocessed high slices, lowest pending slice at bit 0.
      if (k == 0) begin : g_src
        assign a_nx = a[WIDTH-1:S];
        assign b_nx = sub ? ~b[WIDTH-1:S] : b[WIDTH-1:S];
      end else begin : g_src
        localparam int unsigned PRW = WIDTH - k * S;
        assign a_nx = stg[k-1].g_rem.a_rem[PRW-1:S];
        assign b_nx = stg[k-1].g_rem.b_rem[PRW-1:S];
      end

      // Inter-slice carry and skewed operand registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          c_q   <= 1'b0;
          a_rem <= '0;
          b_rem <= '0;
`ifdef PIPELINED_ADDSUB_FLAGS_EN
          z_q   <= 1'b0;
`endif
        end else if (adv && vin) begin
          c_q   <= c_out;
          a_rem <= a_nx;
          b_rem <= b_nx;
`ifdef PIPELINED_ADDSUB_FLAGS_EN
          z_q   <= z_in & (s_s == '0);
`endif
        end
      end
    end else begin : g_last
`ifdef PIPELINED_ADDSUB_FLAGS_EN
      logic c_out;
      logic n_q;
      logic z_q;
      logic c_q;
      logic v_q;

      assign {c_out, s_s} = {1'b0, a_s} + {1'b0, b_s} + SW'(c_in);

      // NZCV from the MSB slice; Z folds in the zero status of the lower slices.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          n_q <= 1'b0;
          z_q <= 1'b0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv && vin) begin
          n_q <= s_s[S-1];
          z_q <= z_in & (s_s == '0);
          c_q <= c_out;
          v_q <= (a_s[S-1] == b_s[S-1]) && (s_s[S-1] != a_s[S-1]);
        end
      end
`else
      assign s_s = a_s + b_s + S'(c_in);
`endif
    end

    // Stage valid bit and de-skewed partial result.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld <= 1'b0;
        res <= '0;
      end else if (adv) begin
        vld <= vin;
        if (vin) res <= res_in;
      end
    end
  end

  assign out_valid = stg[STAGES-1].vld;
  assign result    = stg[STAGES-1].res;

`ifdef PIPELINED_ADDSUB_FLAGS_EN
  assign flag_n = stg[STAGES-1].g_last.n_q;
  assign flag_z = stg[STAGES-1].g_last.z_q;
  assign flag_c = stg[STAGES-1].g_last.c_q;
  assign flag_v = stg[STAGES-1].g_last.v_q;
`else
  assign flag_n = 1'b0;
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=64, STAGES=4); honours PIPELINED_ADDSUB_FLAGS_EN.
`timescale 1ns/1ps
module tb_pipelined_addsub;
  localparam int unsigned W  = 64;
  localparam int unsigned NS = 4;
  localparam int unsigned W1 = W + 1;
  localparam int unsigned W2 = W + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         flag_n, flag_z, flag_c, flag_v;

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   nzcv;
  } exp_t;

  exp_t expq[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  int   got = 0;
  bit   stop_rand = 1'b0;

  pipelined_addsub #(.WIDTH(W), .STAGES(NS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: plain modular arithmetic; V from exact signed sum out of range.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    exp_t       e;
    logic [W-1:0] be;
    logic       c0;
    be = sb ? ~y : y;
    c0 = sb ? 1'b1 : ci;
`ifdef PIPELINED_ADDSUB_FLAGS_EN
    begin
      logic [W:0]   full;
      logic [W+1:0] st;
      full = {1'b0, x} + {1'b0, be} + W1'(c0);
      st   = {{2{x[W-1]}}, x} + {{2{be[W-1]}}, be} + W2'(c0);
      e.r  = full[W-1:0];
      e.nzcv = {e.r[W-1], e.r == '0, full[W], st != {{2{e.r[W-1]}}, e.r}};
    end
`else
    e.r    = x + be + W'(c0);
    e.nzcv = 4'b0000;
`endif
    return e;
  endfunction

  function automatic logic [3:0] fl_exp(input logic [3:0] f);
`ifdef PIPELINED_ADDSUB_FLAGS_EN
    return f;
`else
    return f & 4'b0000;
`endif
  endfunction

  // Scoreboard: every output transfer must match the oldest accepted op.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got++;
      chk("output_expected", W'(expq.size() != 0), W'(1));
      if (expq.size() != 0) begin
        e_mon = expq.pop_front();
        chk("result", result, e_mon.r);
        chk("nzcv", W'({flag_n, flag_z, flag_c, flag_v}), W'(e_mon.nzcv));
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                      input logic tc, input logic ts);
    int n = 0;
    in_valid = 1'b1; a = ta; b = tb2; cin = tc; sub = ts;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    chk("accept_bound", W'(in_ready), W'(1));
    expq.push_back(model(ta, tb2, tc, ts));
    accepted++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int lat_exp);
    int n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", W'(n), W'(lat_exp));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", W'(expq.size()), W'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      2:       v = {1'b0, {(W-1){1'b1}}};
      3:       v = {1'b1, {(W-1){1'b0}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", result, W'(0));
    chk("rst_flags", W'({flag_n, flag_z, flag_c, flag_v}), W'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", W'(in_ready), W'(1));

    // 1: 5+3
    send(W'(5), W'(3), 1'b0, 1'b0);
    wait_out(NS);
    chk("t1_result", result, W'(8));
    chk("t1_nzcv", W'({flag_n, flag_z, flag_c, flag_v}), W'(fl_exp(4'b0000)));

    // 2: carry through every slice boundary
    send('1, W'(1), 1'b0, 1'b0);
    wait_out(NS);
    chk("t2_result", result, W'(0));
    chk("t2_nzcv", W'({flag_n, flag_z, flag_c, flag_v}), W'(fl_exp(4'b0110)));

    // 3: signed overflow, then borrow
    send({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0);
    wait_out(NS);
    chk("t3a_result", result, {1'b1, {(W-1){1'b0}}});
    chk("t3a_nzcv", W'({flag_n, flag_z, flag_c, flag_v}), W'(fl_exp(4'b1001)));
    send(W'(3), W'(5), 1'b0, 1'b1);
    wait_out(NS);
    chk("t3b_result", result, {{(W-1){1'b1}}, 1'b0});
    chk("t3b_nzcv", W'({flag_n, flag_z, flag_c, flag_v}), W'(fl_exp(4'b1000)));
    send(W'(100), W'(7), 1'b1, 1'b0);
    drain();

    // 4a: back-to-back stream, outputs on consecutive cycles
    fork
      begin
        for (int i = 1; i <= 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
      end
      begin
        repeat (NS) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("stream_consecutive", W'(out_valid), W'(1));
        end
      end
    join
    drain();

    // 4b: same stream with a 3-cycle consumer stall
    fork
      begin
        for (int i = 1; i <= 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", W'(in_ready), W'(0));
          chk("stall_out_valid", W'(out_valid), W'(1));
          chk("stall_result_held", result, expq[0].r);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // 5: asynchronous reset with ops in flight
    for (int i = 0; i < 3; i++) send(W'(40 + i), W'(1), 1'b0, 1'b0);
    #2 reset = 1'b1;
    accepted = accepted - expq.size();
    expq.delete();
    #1;
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_result", result, W'(0));
    chk("arst_flags", W'({flag_n, flag_z, flag_c, flag_v}), W'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    send(W'(10), W'(20), 1'b0, 1'b0);
    wait_out(NS);
    chk("post_rst_result", result, W'(30));
    drain();

    // Randomised traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("all_received", W'(got), W'(accepted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
